// File: rtl/deserializer_align_if.sv
// Beat-side and frame-side signals of the aligning deserializer.
// The master drives beats and controls; the slave returns frames and alignment status.
interface deserializer_align_if #(
    parameter int unsigned D = 8,
    parameter int unsigned S = 4
);
    logic [D-1:0]         data_in;
    logic                 train_enable;
    logic                 bitslip;
    logic [D*S-1:0]       data_out;
    logic                 data_out_valid;
    logic                 locked;
    logic [$clog2(S)-1:0] slip_count;

    modport master (
        output data_in,
        output train_enable,
        output bitslip,
        input  data_out,
        input  data_out_valid,
        input  locked,
        input  slip_count
    );

    modport slave (
        input  data_in,
        input  train_enable,
        input  bitslip,
        output data_out,
        output data_out_valid,
        output locked,
        output slip_count
    );
endinterface

// File: rtl/deserializer_align.sv
// D-bit to D*S-bit deserializer with a frame-valid strobe, manual beat slip and a
// training-pattern alignment FSM; everything runs on high_speed_clock.
module deserializer_align #(
    parameter int unsigned    D             = 8,
    parameter int unsigned    S             = 4,
    parameter int unsigned    INITIAL_S     = 0,
    parameter logic [D*S-1:0] TRAIN_PATTERN = 32'hA55AF00F,
    parameter int unsigned    LOCK_COUNT    = 4
) (
    input  logic                high_speed_clock,
    input  logic                reset,
    deserializer_align_if.slave bus
);
    localparam int unsigned   CW         = $clog2(S);
    localparam int unsigned   MW         = $clog2(LOCK_COUNT + 1);
    localparam int unsigned   SHW        = D * (S - 1);
    localparam logic [CW-1:0] LAST_BEAT  = CW'(S - 1);
    localparam logic [MW-1:0] LAST_MATCH = MW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [MW-1:0]  match_cnt;
    logic [MW-1:0]  match_cnt_n;
    logic           locked_r;
    logic           locked_n;
    logic           slip_pend;
    logic           slip_pend_n;

    logic [SHW-1:0] shift;
    logic [SHW-1:0] shift_next;
    logic [CW-1:0]  beat_cnt;
    logic [CW-1:0]  slip_cnt;
    logic [D*S-1:0] data_out_r;
    logic           valid_r;

    logic           manual_slip;
    logic           auto_slip;
    logic           slip;
    logic           frame_done;
    logic [D*S-1:0] frame;
    logic           match;

    // Oldest beat sits at the LSB end; the newest enters at the MSB end.
    if (S > 2) begin : g_shift_wide
        assign shift_next = {bus.data_in, shift[SHW-1:D]};
    end else begin : g_shift_single
        assign shift_next = bus.data_in;
    end

    always_comb begin
        manual_slip = (state == IDLE) && !bus.train_enable && bus.bitslip;
        // A search-mode slip requested at a mismatching frame lands on the following cycle.
        auto_slip   = (state == SEARCH) && bus.train_enable && slip_pend;
        slip        = manual_slip || auto_slip;
        frame_done  = (beat_cnt == LAST_BEAT) && !slip;
        frame       = {bus.data_in, shift};
        match       = (frame == TRAIN_PATTERN);
    end

    always_comb begin
        state_n     = state;
        match_cnt_n = match_cnt;
        locked_n    = locked_r;
        slip_pend_n = 1'b0;

        if (manual_slip) begin
            locked_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (bus.train_enable) begin
                    state_n     = SEARCH;
                    locked_n    = 1'b0;
                    match_cnt_n = '0;
                end
            end
            SEARCH: begin
                if (!bus.train_enable) begin
                    state_n = IDLE;
                end else if (frame_done) begin
                    if (match) begin
                        if (LOCK_COUNT == 1) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                        end else begin
                            state_n = VERIFY;
                        end
                        match_cnt_n = MW'(1);
                    end else begin
                        slip_pend_n = 1'b1;
                    end
                end
            end
            VERIFY: begin
                if (!bus.train_enable) begin
                    state_n = IDLE;
                end else if (frame_done) begin
                    if (match) begin
                        match_cnt_n = match_cnt + 1'b1;
                        if (match_cnt == LAST_MATCH) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                        end
                    end else begin
                        // Phase was right once already, so retry without slipping.
                        state_n     = SEARCH;
                        match_cnt_n = '0;
                    end
                end
            end
            LOCKED: begin
                if (!bus.train_enable) begin
                    state_n = IDLE;
                end else if (frame_done && !match) begin
                    state_n     = SEARCH;
                    locked_n    = 1'b0;
                    match_cnt_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge high_speed_clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            match_cnt <= '0;
            locked_r  <= 1'b0;
            slip_pend <= 1'b0;
        end else begin
            state     <= state_n;
            match_cnt <= match_cnt_n;
            locked_r  <= locked_n;
            slip_pend <= slip_pend_n;
        end
    end

    always_ff @(posedge high_speed_clock or posedge reset) begin
        if (reset) begin
            shift      <= '0;
            beat_cnt   <= CW'(INITIAL_S);
            slip_cnt   <= '0;
            data_out_r <= '0;
            valid_r    <= 1'b0;
        end else begin
            shift   <= shift_next;
            valid_r <= frame_done;
            if (frame_done) begin
                data_out_r <= frame;
            end
            if (slip) begin
                slip_cnt <= (slip_cnt == LAST_BEAT) ? '0 : slip_cnt + 1'b1;
            end else begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    assign bus.data_out       = data_out_r;
    assign bus.data_out_valid = valid_r;
    assign bus.locked         = locked_r;
    assign bus.slip_count     = slip_cnt;
endmodule

// File: doc/deserializer_align.md
Name: deserializer_align

Overview:
- Parametrised successor to the basic D-bit to D*S-bit deserializer.
- Adds a one-cycle frame-valid strobe and a manual beat-slip input.
- Adds a training-pattern word-alignment FSM that slips the frame boundary until frames match a known pattern, then reports lock.
- Sits between the DDR capture front end and the wide-word consumer; runs entirely on the high-speed clock.

Parameters:
- D, 8, data bitwidth per beat.
- S, 4, deserialization ratio (beats per frame); S >= 2.
- INITIAL_S, 0, beat-counter value after reset; 0..S-1.
- TRAIN_PATTERN, 32'hA55AF00F, D*S-bit expected aligned frame.
- LOCK_COUNT, 4, consecutive matching frames required to declare lock; >= 1.

Ports:
- high_speed_clock  input  1  sole clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- data_in  input  D  one beat per cycle.
- train_enable  input  1  level; 1 = run automatic alignment.
- bitslip  input  1  single-cycle pulse; manual slip, honoured only in IDLE.
- data_out  output  D*S  assembled frame; oldest beat at LSB, newest at MSB.
- data_out_valid  output  1  one-cycle pulse when data_out updates.
- locked  output  1  alignment verified.
- slip_count  output  $clog2(S)  total slips applied, mod S.

Behaviour:
- Reset (async assert, sync release): data_out=0, data_out_valid=0, locked=0, slip_count=0, match counter=0, FSM=IDLE, beat counter=INITIAL_S, shift register=0.
- Shift register: D*(S-1) bits. Each cycle, data_in is inserted at the MSB and the oldest beat is dropped from the LSB.
- Beat counter: increments mod S each cycle unless a slip is active.
- Frame completion: on a cycle with counter==S-1 and no slip, the register stage captures data_out <= {data_in, shift}. data_out_valid is 1 for exactly that following cycle.
- Latency: last beat sampled at edge N, so frame and valid are visible after edge N+1.
- Slip: holds the beat counter for one cycle and increments slip_count (wraps at S). The frame in progress absorbs one extra beat, so the boundary moves one beat later. At most one slip per frame.
- FSM states: IDLE, SEARCH, VERIFY, LOCKED. Comparisons are made only at frame completion, against {data_in, shift}.
  - IDLE: free-running deserializer.
    - bitslip=1 -> slip and clear locked.
    - train_enable=1 -> SEARCH; locked=0; match counter=0.
  - SEARCH:
    - match -> VERIFY with match counter=1, or straight to LOCKED if LOCK_COUNT==1.
    - mismatch -> slip on the next cycle; stay in SEARCH.
  - VERIFY:
    - match -> match counter increments; when it reaches LOCK_COUNT -> LOCKED and locked=1.
    - mismatch -> SEARCH, match counter=0, no slip on that frame.
  - LOCKED: mismatch while train_enable=1 -> SEARCH; locked=0 in the same cycle data_out_valid is asserted.
  - train_enable=0 in SEARCH/VERIFY/LOCKED -> IDLE at the next edge.
    - locked keeps its value: 1 if leaving LOCKED, else 0.
    - Phase is frozen.
- bitslip outside IDLE is ignored.
- Simultaneous bitslip and train_enable rising in IDLE: train_enable wins; bitslip is ignored.
- Worst-case lock time from SEARCH entry, for a clean repeating pattern: (S-1)*(S+1) + LOCK_COUNT*S + S cycles.
- Reset mid-frame or mid-training: async clear as above. Any partial frame is discarded; no valid pulse.

Test Plan:
- Defaults apply unless stated (D=8, S=4, INITIAL_S=0).
- Passthrough: stream 01,02,03,... after reset release, train_enable=0 -> data_out=32'h04030201 with a 1-cycle valid, then 32'h08070605 4 cycles later; valid exactly every 4th cycle.
- Manual slip: after frame 04030201, pulse bitslip during beat 05 -> next frame 32'h09080706 (valid 5 cycles after previous); slip_count=1; then 0D0C0B0A.
- Training lock: stream repeating beats 5A,A5,0F,F0 (pattern offset by 2), train_enable=1 -> exactly 2 slips; then 4 consecutive frames of 32'hA55AF00F; locked rises within the worst-case bound; slip_count=2.
- VERIFY failure: during VERIFY replace one beat with 00 -> FSM returns to SEARCH, locked stays 0. Clean data resumes -> locks after 4 further matching frames; slip_count unchanged (phase already correct).
- Lock loss and freeze: in LOCKED with train_enable=1, corrupt one frame -> locked=0 coincident with that frame's valid. Re-lock, then drop train_enable -> locked stays 1. Pulse bitslip -> locked=0; slip_count increments.
- Async reset mid-frame: assert reset between clock edges at beat 3 of a frame -> data_out=0, valid=0, locked=0 immediately (before the next edge). After release, first frame completes 4 cycles later.
